// File: rtl/iir_sched_pkg.sv
// Shared types and sizing helpers for the time-multiplexed IIR lowpass scheduler.
package iir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    OUT   = 2'd2
  } sched_state_e;

  // Accumulator width: sample plus headroom for the 2^k gain of a pow2k stage.
  function automatic int acc_bits(input int input_bits, input int shift);
    return input_bits + shift;
  endfunction

  function automatic int ch_bits(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/iir_lowpass_channel_scheduler_stage_update.sv
// Combinational pow2k lowpass stage: acc' = acc - (acc >> k) + x, plus the scaled stage output.
module iir_pow2k_stage_update #(
  parameter int ACC_BITS          = 35,
  parameter int FILTER_SHIFT_BITS = 5
) (
  input  logic [ACC_BITS-1:0] acc_i,
  input  logic [ACC_BITS-1:0] x_i,
  output logic [ACC_BITS-1:0] acc_o,
  output logic [ACC_BITS-1:0] stage_o
);

  // Cannot overflow: acc never exceeds x_max << k, which fits in ACC_BITS.
  assign acc_o   = acc_i - (acc_i >> FILTER_SHIFT_BITS) + x_i;
  assign stage_o = acc_o >> FILTER_SHIFT_BITS;

endmodule

// File: rtl/iir_lowpass_channel_scheduler.sv
// Round-robin scheduler sharing one pow2k IIR stage datapath across channels and cascaded stages.
// Optional IIR_SCHED_WARMSTART_EN: first sample of an unprimed channel preloads every stage.
module iir_lowpass_channel_scheduler
  import iir_sched_pkg::*;
#(
  parameter int CHANNELS          = 2,
  parameter int INPUT_BITS        = 30,
  parameter int RESULT_BITS       = 30,
  parameter int FILTER_SHIFT_BITS = 5,
  parameter int FILTER_STAGES     = 2,
  localparam int CH_BITS          = ch_bits(CHANNELS)
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           CE,
  input  logic                           FLUSH,
  input  logic [CHANNELS-1:0]            REQ_VALID,
  input  logic [CHANNELS*INPUT_BITS-1:0] REQ_DATA,
  output logic [CHANNELS-1:0]            REQ_READY,
  output logic                           OUT_VALID,
  output logic [CH_BITS-1:0]             OUT_CHANNEL,
  output logic [RESULT_BITS-1:0]         OUT_VALUE,
  output logic                           BUSY
);

  localparam int ACC_BITS = acc_bits(INPUT_BITS, FILTER_SHIFT_BITS);
  localparam int SB       = ch_bits(FILTER_STAGES);
  localparam logic [SB-1:0] LAST_STAGE = SB'(FILTER_STAGES - 1);

  sched_state_e           state_q;
  logic [CH_BITS-1:0]     rr_ptr_q;
  logic [CH_BITS-1:0]     ch_q;
  logic [SB-1:0]          stage_q;
  logic [INPUT_BITS-1:0]  sample_q;
  logic [ACC_BITS-1:0]    carry_q;
  logic [ACC_BITS-1:0]    acc_q [CHANNELS][FILTER_STAGES];
  logic                   out_vld_q;
  logic [CH_BITS-1:0]     out_ch_q;
  logic [RESULT_BITS-1:0] out_val_q;
  logic                   busy_q;

  logic                   can_grant;
  logic                   any_vld;
  logic                   accept;
  logic [CH_BITS-1:0]     grant_ch;

  logic [ACC_BITS-1:0]    acc_cur;
  logic [ACC_BITS-1:0]    x_cur;
  logic [ACC_BITS-1:0]    acc_upd;
  logic [ACC_BITS-1:0]    stage_out;
  logic [ACC_BITS-1:0]    wr_val;
  logic [ACC_BITS-1:0]    wr_carry;

  // Round robin: lowest valid index above rr_ptr wins, otherwise wrap to the lowest valid index.
  always_comb begin
    grant_ch = '0;
    any_vld  = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (REQ_VALID[i]) begin
        grant_ch = CH_BITS'(i);
        any_vld  = 1'b1;
      end
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (REQ_VALID[i] && (i > int'(rr_ptr_q))) begin
        grant_ch = CH_BITS'(i);
      end
    end
  end

  assign can_grant = RESET_N && CE && !FLUSH && (state_q == IDLE);
  assign accept    = can_grant && any_vld;

  always_comb begin
    REQ_READY = '0;
    if (accept) begin
      REQ_READY[grant_ch] = 1'b1;
    end
  end

  assign acc_cur = acc_q[ch_q][stage_q];
  assign x_cur   = (stage_q == '0) ? {{FILTER_SHIFT_BITS{1'b0}}, sample_q} : carry_q;

  iir_pow2k_stage_update #(
    .ACC_BITS          (ACC_BITS),
    .FILTER_SHIFT_BITS (FILTER_SHIFT_BITS)
  ) u_stage (
    .acc_i   (acc_cur),
    .x_i     (x_cur),
    .acc_o   (acc_upd),
    .stage_o (stage_out)
  );

`ifdef IIR_SCHED_WARMSTART_EN
  logic [CHANNELS-1:0] primed_q;
  logic                warm_q;

  assign wr_val   = warm_q ? {sample_q, {FILTER_SHIFT_BITS{1'b0}}} : acc_upd;
  assign wr_carry = stage_out;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      primed_q <= '0;
      warm_q   <= 1'b0;
    end else if (CE) begin
      if (FLUSH) begin
        primed_q <= '0;
        warm_q   <= 1'b0;
      end else begin
        if (accept) begin
          warm_q <= ~primed_q[grant_ch];
        end
        if ((state_q == STAGE) && (stage_q == LAST_STAGE)) begin
          primed_q[ch_q] <= 1'b1;
        end
      end
    end
  end
`else
  assign wr_val   = acc_upd;
  assign wr_carry = stage_out;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      rr_ptr_q  <= CH_BITS'(CHANNELS - 1);
      ch_q      <= '0;
      stage_q   <= '0;
      sample_q  <= '0;
      carry_q   <= '0;
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      out_val_q <= '0;
      busy_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int s = 0; s < FILTER_STAGES; s++) begin
          acc_q[c][s] <= '0;
        end
      end
    end else if (CE) begin
      if (FLUSH) begin
        // Abort whatever is in flight; the pending result is dropped, never strobed.
        state_q   <= IDLE;
        stage_q   <= '0;
        out_vld_q <= 1'b0;
        busy_q    <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          for (int s = 0; s < FILTER_STAGES; s++) begin
            acc_q[c][s] <= '0;
          end
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              sample_q <= REQ_DATA[int'(grant_ch)*INPUT_BITS +: INPUT_BITS];
              ch_q     <= grant_ch;
              rr_ptr_q <= grant_ch;
              stage_q  <= '0;
              busy_q   <= 1'b1;
              state_q  <= STAGE;
            end
          end
          STAGE: begin
            acc_q[ch_q][stage_q] <= wr_val;
            carry_q              <= wr_carry;
            if (stage_q == LAST_STAGE) begin
              out_vld_q <= 1'b1;
              out_ch_q  <= ch_q;
              out_val_q <= wr_val[ACC_BITS-1 -: RESULT_BITS];
              state_q   <= OUT;
            end else begin
              stage_q <= stage_q + 1'b1;
            end
          end
          OUT: begin
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
          default: begin
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign OUT_VALID   = out_vld_q;
  assign OUT_CHANNEL = out_ch_q;
  assign OUT_VALUE   = out_val_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_iir_lowpass_channel_scheduler.sv
// Randomized bench for iir_lowpass_channel_scheduler against a transaction-level filter model.
module tb_iir_lowpass_channel_scheduler;

  localparam int CH  = 2;
  localparam int IB  = 30;
  localparam int RB  = 30;
  localparam int SH  = 5;
  localparam int FS  = 2;
  localparam int ACC = IB + SH;
  localparam int CHB = 1;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              CE = 1'b1;
  logic              FLUSH = 1'b0;
  logic [CH-1:0]     req_valid = '0;
  logic [CH*IB-1:0]  req_data = '0;
  logic [CH-1:0]     req_ready;
  logic              out_valid;
  logic [CHB-1:0]    out_channel;
  logic [RB-1:0]     out_value;
  logic              busy;

  iir_lowpass_channel_scheduler #(
    .CHANNELS(CH), .INPUT_BITS(IB), .RESULT_BITS(RB),
    .FILTER_SHIFT_BITS(SH), .FILTER_STAGES(FS)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .FLUSH(FLUSH),
    .REQ_VALID(req_valid), .REQ_DATA(req_data), .REQ_READY(req_ready),
    .OUT_VALID(out_valid), .OUT_CHANNEL(out_channel), .OUT_VALUE(out_value),
    .BUSY(busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: per-channel stage accumulators, updated in one go when a sample is accepted.
  typedef struct {
    int              ch;
    longint unsigned val;
    int              cyc;
  } exp_t;

  longint unsigned macc [CH+1][FS];
  bit              primed [CH];
  int              rr = CH - 1;
  int              cyc = 0;
  int              free_cyc = 0;
  exp_t            q[$];
  bit              mono_en = 1'b0;
  bit              iso_en = 1'b0;
  longint unsigned last0 = 0;

  function automatic longint unsigned mfilt(int ch, longint unsigned x);
    longint unsigned v = x;
    for (int s = 0; s < FS; s++) begin
      macc[ch][s] = macc[ch][s] - (macc[ch][s] >> SH) + v;
      v = macc[ch][s] >> SH;
    end
    return macc[ch][FS-1] >> (ACC - RB);
  endfunction

  function automatic void mclear();
    for (int c = 0; c <= CH; c++)
      for (int s = 0; s < FS; s++) macc[c][s] = 0;
    for (int c = 0; c < CH; c++) primed[c] = 1'b0;
  endfunction

  // Compare process: checks outputs once per cycle, then advances the model across the edge.
  initial begin
    logic [CH-1:0]   er;
    bit              ev;
    int              gch;
    longint unsigned x;
    longint unsigned val;
    mclear();
    forever begin
      @(negedge CLK);
      #2;
      if (!RESET_N) begin
        chk("rst_valid", out_valid, 0);
        chk("rst_channel", out_channel, 0);
        chk("rst_value", out_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        mclear();
        q.delete();
        rr = CH - 1;
        free_cyc = cyc;
      end else begin
        ev = (q.size() > 0) && (q[0].cyc == cyc);
        chk("out_valid", out_valid, ev);
        if (ev) begin
          chk("out_channel", out_channel, q[0].ch);
          chk("out_value", out_value, q[0].val);
          if (mono_en && q[0].ch == 0) begin
            chk("monotonic", (out_value >= last0), 1);
            last0 = out_value;
          end
          if (iso_en && q[0].ch == 1) chk("isolation", out_value, 0);
        end
        chk("busy", busy, (cyc < free_cyc));
        er = '0;
        gch = -1;
        if (CE && !FLUSH && cyc >= free_cyc) begin
          for (int k = 1; k <= CH; k++)
            if (gch < 0 && req_valid[(rr + k) % CH]) gch = (rr + k) % CH;
        end
        if (gch >= 0) er[gch] = 1'b1;
        chk("ready", req_ready, er);
        if (CE) begin
          if (ev) void'(q.pop_front());
          if (FLUSH) begin
            mclear();
            q.delete();
            free_cyc = cyc + 1;
          end else if (gch >= 0) begin
            x = req_data[gch*IB +: IB];
`ifdef IIR_SCHED_WARMSTART_EN
            if (!primed[gch]) begin
              for (int s = 0; s < FS; s++) macc[gch][s] = x << SH;
              val = macc[gch][FS-1] >> (ACC - RB);
              primed[gch] = 1'b1;
            end else begin
              val = mfilt(gch, x);
            end
`else
            val = mfilt(gch, x);
`endif
            q.push_back('{ch: gch, val: val, cyc: cyc + FS + 1});
            rr = gch;
            free_cyc = cyc + FS + 2;
          end
          cyc++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input int ch, input logic [IB-1:0] d);
    bit got = 1'b0;
    @(posedge CLK); #1;
    req_valid[ch] = 1'b1;
    req_data[ch*IB +: IB] = d;
    for (int i = 0; i < 60 && !got; i++) begin
      #2;
      if (req_ready[ch] && CE) got = 1'b1;
      @(posedge CLK); #1;
    end
    req_valid[ch] = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(output longint unsigned v);
    bit got = 1'b0;
    v = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK); #3;
      if (out_valid) begin
        got = 1'b1;
        v = out_value;
      end
    end
    if (!got) chk("out_timeout", 0, 1);
  endtask

  task automatic flush_pulse();
    @(posedge CLK); #1;
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
  endtask

  initial begin
    longint unsigned v;

    // Pin the model with hand-derived values on the scratch channel.
    for (int s = 0; s < FS; s++) macc[CH][s] = 0;
    chk("pin_from_zero_14ff", mfilt(CH, 30'h14FF_0000), 30'h0005_3FC0);
    for (int s = 0; s < FS; s++) macc[CH][s] = 0;
    chk("pin_from_zero_max", mfilt(CH, 30'h3FFF_FFFF), 30'h000F_FFFF);
    for (int s = 0; s < FS; s++) macc[CH][s] = 64'h00FF_FFFF << SH;
    chk("pin_steady", mfilt(CH, 30'h00FF_FFFF), 30'h00FF_FFFF);

    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Constant ramp on channel 0.
    last0 = 0;
    mono_en = 1'b1;
    for (int i = 0; i < 1500; i++) send(0, 30'h00FF_FFFF);
    repeat (4) @(posedge CLK);
    mono_en = 1'b0;
    chk("converged", last0, 30'h00FF_FFFF);

    // Both channels contending.
    for (int i = 0; i < 48; i++) begin
      @(posedge CLK); #1;
      req_valid = '1;
      req_data = {IB'($urandom), IB'($urandom)};
    end
    @(posedge CLK); #1;
    req_valid = '0;
    repeat (5) @(posedge CLK);

    // Isolation of channel 1 from a full-scale channel 0.
    flush_pulse();
    iso_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(0, 30'h3FFF_FFFF);
      send(1, 30'h0);
    end
    repeat (5) @(posedge CLK);
    iso_en = 1'b0;

    // FLUSH while a sample is in STAGE.
    send(0, IB'($urandom));
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    send(0, 30'h14FF_0000);
    wait_out(v);
    chk("flush_then_sample", v, 30'h0005_3FC0);

    // Random traffic with clock-enable gaps and occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      @(posedge CLK); #1;
      req_valid = CH'($urandom);
      req_data = {IB'($urandom), IB'($urandom)};
      CE = ($urandom % 6) != 0;
      FLUSH = CE && (($urandom % 97) == 0);
    end
    @(posedge CLK); #1;
    req_valid = '0;
    CE = 1'b1;
    FLUSH = 1'b0;
    repeat (6) @(posedge CLK);

    // Reset while the result is being presented.
    send(0, 30'h0123_4567);
    wait_out(v);
    RESET_N = 1'b0;
    #1;
    chk("reset_in_out_valid", out_valid, 0);
    chk("reset_in_out_value", out_value, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    req_valid = '1;
    #2;
    chk("first_grant_after_reset", req_ready, 2'b01);
    @(posedge CLK); #1;
    req_valid = '0;
    repeat (6) @(posedge CLK);

`ifdef IIR_SCHED_WARMSTART_EN
    flush_pulse();
    send(1, 30'h1345_F234);
    wait_out(v);
    chk("warm_first", v, 30'h1345_F234);
    send(1, 30'h0000_1000);
    wait_out(v);
    flush_pulse();
    send(1, 30'h2AAA_5555);
    wait_out(v);
    chk("warm_reprime", v, 30'h2AAA_5555);
    repeat (4) @(posedge CLK);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
